// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DATA_W / PTR_W : default register data and pointer widths
//   REG_ZERO       : index of the hard-wired zero register
//   req_e          : identifies a writeback requester (ALU or MEM)
package rf_pkg;
  localparam int DATA_W   = 8;
  localparam int PTR_W    = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;
endpackage

// File: rtl/wb_hold.sv
// One-entry writeback holding register.
//   clk, reset      : clock, asynchronous active-high reset
//   load            : capture in_ptr/in_data and mark the entry full
//   drain           : entry is being written this cycle; it empties unless load
//   in_ptr, in_data : incoming destination register and value
//   full, ptr, data : current entry state
module wb_hold #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic [PTR_W-1:0]  in_ptr,
  input  logic [DATA_W-1:0] in_data,
  output logic              full,
  output logic [PTR_W-1:0]  ptr,
  output logic [DATA_W-1:0] data
);
  logic              full_reg, full_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic [DATA_W-1:0] data_reg, data_next;

  // A load at the same edge as a drain wins, so a requester can stream
  // one entry per cycle through this single slot.
  always_comb begin
    full_next = full_reg;
    ptr_next  = ptr_reg;
    data_next = data_reg;
    if (load) begin
      full_next = 1'b1;
      ptr_next  = in_ptr;
      data_next = in_data;
    end else if (drain) begin
      full_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_reg <= 1'b0;
      ptr_reg  <= '0;
      data_reg <= '0;
    end else begin
      full_reg <= full_next;
      ptr_reg  <= ptr_next;
      data_reg <= data_next;
    end
  end

  assign full = full_reg;
  assign ptr  = ptr_reg;
  assign data = data_reg;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with hazard forwarding.
//   clk, reset                      : clock, asynchronous active-high reset
//   alu_valid/ptr/data, alu_ready   : ALU writeback request handshake
//   mem_valid/ptr/data, mem_ready   : load writeback request handshake
//   rf_we, rf_ptr_w, rf_di          : register file write port
//   chk_ptr, chk_busy, chk_data     : hazard query and forwarded value
// Each requester owns one holding entry; the older full entry is written
// first so two writes to the same register commit in acceptance order.
module rf_wb_arbiter #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int PTR_W  = rf_pkg::PTR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [PTR_W-1:0]  alu_ptr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [PTR_W-1:0]  mem_ptr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [PTR_W-1:0]  rf_ptr_w,
  output logic [DATA_W-1:0] rf_di,
  input  logic [PTR_W-1:0]  chk_ptr,
  output logic              chk_busy,
  output logic [DATA_W-1:0] chk_data
);
  import rf_pkg::*;

  localparam logic [PTR_W-1:0] ZERO_PTR = PTR_W'(REG_ZERO);

  logic              alu_full, mem_full;
  logic [PTR_W-1:0]  alu_hptr, mem_hptr;
  logic [DATA_W-1:0] alu_hdata, mem_hdata;
  logic              grant_valid, grant_alu, grant_mem;
  req_e              grant_sel;
  req_e              older_reg, older_next;
  logic              alu_load, mem_load, alu_keep, mem_keep;
  logic              alu_match, mem_match;

  wb_hold #(.DATA_W(DATA_W), .PTR_W(PTR_W)) u_alu_hold (
    .clk(clk), .reset(reset), .load(alu_load), .drain(grant_alu),
    .in_ptr(alu_ptr), .in_data(alu_data),
    .full(alu_full), .ptr(alu_hptr), .data(alu_hdata)
  );

  wb_hold #(.DATA_W(DATA_W), .PTR_W(PTR_W)) u_mem_hold (
    .clk(clk), .reset(reset), .load(mem_load), .drain(grant_mem),
    .in_ptr(mem_ptr), .in_data(mem_data),
    .full(mem_full), .ptr(mem_hptr), .data(mem_hdata)
  );

  // Grant depends only on entry state, which keeps ready free of any
  // combinational path from the valid inputs.
  always_comb begin
    grant_valid = alu_full | mem_full;
    grant_sel   = REQ_ALU;
    if (alu_full && mem_full) grant_sel = older_reg;
    else if (mem_full)        grant_sel = REQ_MEM;
  end

  assign grant_alu = grant_valid && (grant_sel == REQ_ALU);
  assign grant_mem = grant_valid && (grant_sel == REQ_MEM);

  assign alu_ready = !alu_full || grant_alu;
  assign mem_ready = !mem_full || grant_mem;
  assign alu_load  = alu_valid && alu_ready;
  assign mem_load  = mem_valid && mem_ready;

  // An entry that stays full across the edge makes a newly loaded entry younger.
  assign alu_keep = alu_full && !grant_alu;
  assign mem_keep = mem_full && !grant_mem;

  always_comb begin
    older_next = older_reg;
    if (alu_load && mem_load) older_next = REQ_MEM;
    else if (alu_load)        older_next = mem_keep ? REQ_MEM : REQ_ALU;
    else if (mem_load)        older_next = alu_keep ? REQ_ALU : REQ_MEM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) older_reg <= REQ_MEM;
    else       older_reg <= older_next;
  end

  // Write port: the granted entry drains even when it targets the zero
  // register, but no write is issued for it.
  always_comb begin
    rf_we    = 1'b0;
    rf_ptr_w = '0;
    rf_di    = '0;
    if (grant_alu) begin
      rf_ptr_w = alu_hptr;
      rf_di    = alu_hdata;
      rf_we    = (alu_hptr != ZERO_PTR);
    end else if (grant_mem) begin
      rf_ptr_w = mem_hptr;
      rf_di    = mem_hdata;
      rf_we    = (mem_hptr != ZERO_PTR);
    end
  end

  // Hazard query: the youngest matching entry holds the value the register
  // file will finally contain.
  assign alu_match = alu_full && (alu_hptr == chk_ptr) && (chk_ptr != ZERO_PTR);
  assign mem_match = mem_full && (mem_hptr == chk_ptr) && (chk_ptr != ZERO_PTR);
  assign chk_busy  = alu_match | mem_match;

  always_comb begin
    chk_data = '0;
    if (alu_match && mem_match) chk_data = (older_reg == REQ_ALU) ? mem_hdata : alu_hdata;
    else if (alu_match)         chk_data = alu_hdata;
    else if (mem_match)         chk_data = mem_hdata;
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int DATA_W = 8;
  localparam int PTR_W  = 5;

  logic              clk;
  logic              reset;
  logic              alu_valid, mem_valid;
  logic [PTR_W-1:0]  alu_ptr, mem_ptr, chk_ptr;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic              alu_ready, mem_ready;
  logic              rf_we;
  logic [PTR_W-1:0]  rf_ptr_w;
  logic [DATA_W-1:0] rf_di;
  logic              chk_busy;
  logic [DATA_W-1:0] chk_data;

  int checks   = 0;
  int failures = 0;

  rf_wb_arbiter #(.DATA_W(DATA_W), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ptr(alu_ptr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_ptr(mem_ptr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_ptr_w(rf_ptr_w), .rf_di(rf_di),
    .chk_ptr(chk_ptr), .chk_busy(chk_busy), .chk_data(chk_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 0; mem_valid = 0;
    alu_ptr = '0; mem_ptr = '0; alu_data = '0; mem_data = '0; chk_ptr = 5'd1;
    @(negedge clk);
    checks++;
    if ({alu_ready, mem_ready, rf_we, chk_busy} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_flags got ar=%b mr=%b we=%b busy=%b want 1 1 0 0", alu_ready, mem_ready, rf_we, chk_busy);
    end
    checks++;
    if (chk_data !== 8'h00 || rf_ptr_w !== 5'd0 || rf_di !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got chk_data=%h ptr=%0d di=%h want 00 0 00", chk_data, rf_ptr_w, rf_di);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset got we=%b ar=%b mr=%b want 0 1 1", rf_we, alu_ready, mem_ready);
    end
  endtask

  task automatic test_single();
    alu_valid = 1; alu_ptr = 5'd3; alu_data = 8'h5A; chk_ptr = 5'd3;
    @(negedge clk);
    alu_valid = 0;
    checks++;
    if (rf_we !== 1'b1 || rf_ptr_w !== 5'd3 || rf_di !== 8'h5A) begin
      failures++;
      $display("FAIL single_write got we=%b ptr=%0d di=%h want 1 3 5a", rf_we, rf_ptr_w, rf_di);
    end
    checks++;
    if (chk_busy !== 1'b1 || chk_data !== 8'h5A) begin
      failures++;
      $display("FAIL single_fwd got busy=%b data=%h want 1 5a", chk_busy, chk_data);
    end
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || chk_busy !== 1'b0 || rf_di !== 8'h00) begin
      failures++;
      $display("FAIL single_drained got we=%b busy=%b di=%h want 0 0 00", rf_we, chk_busy, rf_di);
    end
  endtask

  task automatic test_simultaneous();
    alu_valid = 1; alu_ptr = 5'd2; alu_data = 8'h21;
    mem_valid = 1; mem_ptr = 5'd4; mem_data = 8'h41;
    chk_ptr = 5'd2;
    @(negedge clk);
    alu_valid = 0; mem_valid = 0;
    checks++;
    if (rf_we !== 1'b1 || rf_ptr_w !== 5'd4 || rf_di !== 8'h41) begin
      failures++;
      $display("FAIL simul_mem_first got we=%b ptr=%0d di=%h want 1 4 41", rf_we, rf_ptr_w, rf_di);
    end
    checks++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_ready got ar=%b mr=%b want 0 1", alu_ready, mem_ready);
    end
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_ptr_w !== 5'd2 || rf_di !== 8'h21 || alu_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_alu_second got we=%b ptr=%0d di=%h ar=%b want 1 2 21 1", rf_we, rf_ptr_w, rf_di, alu_ready);
    end
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL simul_idle got we=%b want 0", rf_we);
    end
  endtask

  task automatic test_same_ptr();
    // MEM then ALU to the same register, one cycle apart.
    mem_valid = 1; mem_ptr = 5'd5; mem_data = 8'h11; chk_ptr = 5'd5;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_ptr_w !== 5'd5 || rf_di !== 8'h11 || chk_data !== 8'h11) begin
      failures++;
      $display("FAIL same_ptr_first got we=%b ptr=%0d di=%h fwd=%h want 1 5 11 11", rf_we, rf_ptr_w, rf_di, chk_data);
    end
    mem_valid = 0;
    alu_valid = 1; alu_ptr = 5'd5; alu_data = 8'h22;
    @(negedge clk);
    alu_valid = 0;
    checks++;
    if (rf_we !== 1'b1 || rf_di !== 8'h22 || chk_busy !== 1'b1 || chk_data !== 8'h22) begin
      failures++;
      $display("FAIL same_ptr_second got we=%b di=%h busy=%b fwd=%h want 1 22 1 22", rf_we, rf_di, chk_busy, chk_data);
    end
    // Both accepted at the same edge: MEM older, forward the ALU value.
    alu_valid = 1; alu_ptr = 5'd7; alu_data = 8'h33;
    mem_valid = 1; mem_ptr = 5'd7; mem_data = 8'h44; chk_ptr = 5'd7;
    @(negedge clk);
    checks++;
    if (rf_di !== 8'h44 || chk_data !== 8'h33 || chk_busy !== 1'b1) begin
      failures++;
      $display("FAIL youngest_fwd got di=%h fwd=%h busy=%b want 44 33 1", rf_di, chk_data, chk_busy);
    end
    // MEM refills while ALU waits: ALU becomes the older entry.
    alu_valid = 0; mem_data = 8'h55;
    @(negedge clk);
    mem_valid = 0;
    checks++;
    if (rf_we !== 1'b1 || rf_di !== 8'h33 || chk_data !== 8'h55) begin
      failures++;
      $display("FAIL age_flip got we=%b di=%h fwd=%h want 1 33 55", rf_we, rf_di, chk_data);
    end
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_di !== 8'h55) begin
      failures++;
      $display("FAIL age_flip_last got we=%b di=%h want 1 55", rf_we, rf_di);
    end
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || chk_busy !== 1'b0 || chk_data !== 8'h00) begin
      failures++;
      $display("FAIL same_ptr_idle got we=%b busy=%b fwd=%h want 0 0 00", rf_we, chk_busy, chk_data);
    end
  endtask

  task automatic test_zero_ptr();
    alu_valid = 1; alu_ptr = 5'd0; alu_data = 8'hFF; chk_ptr = 5'd0;
    @(negedge clk);
    alu_valid = 0;
    checks++;
    if (rf_we !== 1'b0 || chk_busy !== 1'b0 || chk_data !== 8'h00 || alu_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_ptr got we=%b busy=%b fwd=%h ar=%b want 0 0 00 1", rf_we, chk_busy, chk_data, alu_ready);
    end
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || rf_di !== 8'h00) begin
      failures++;
      $display("FAIL zero_ptr_drained got we=%b di=%h want 0 00", rf_we, rf_di);
    end
  endtask

  task automatic test_back_to_back();
    int ac = 0;
    int mc = 0;
    logic acc_a, acc_m;
    logic [PTR_W-1:0]  exp_ptr;
    logic [DATA_W-1:0] exp_di;
    for (int c = 0; c <= 8; c++) begin
      if (c >= 1) begin
        // Expected commit order: M0, A0, M1, A1, ...
        if (((c - 1) % 2) == 0) begin
          exp_ptr = PTR_W'(16 + (c - 1) / 2);
          exp_di  = DATA_W'(8'hB0 + (c - 1) / 2);
        end else begin
          exp_ptr = PTR_W'(8 + (c - 1) / 2);
          exp_di  = DATA_W'(8'hA0 + (c - 1) / 2);
        end
        checks++;
        if (rf_we !== 1'b1 || rf_ptr_w !== exp_ptr || rf_di !== exp_di) begin
          failures++;
          $display("FAIL stream_commit_%0d got we=%b ptr=%0d di=%h want 1 %0d %h", c - 1, rf_we, rf_ptr_w, rf_di, exp_ptr, exp_di);
        end
      end
      alu_valid = (c < 8); alu_ptr = PTR_W'(8 + ac);  alu_data = DATA_W'(8'hA0 + ac);
      mem_valid = (c < 8); mem_ptr = PTR_W'(16 + mc); mem_data = DATA_W'(8'hB0 + mc);
      acc_a = alu_valid && alu_ready;
      acc_m = mem_valid && mem_ready;
      @(negedge clk);
      if (acc_a) ac++;
      if (acc_m) mc++;
    end
    checks++;
    if (ac != 4 || mc != 5) begin
      failures++;
      $display("FAIL stream_accepts got alu=%0d mem=%0d want 4 5", ac, mc);
    end
    // The final MEM entry is still pending and drains now.
    checks++;
    if (rf_we !== 1'b1 || rf_ptr_w !== 5'd20 || rf_di !== 8'hB4) begin
      failures++;
      $display("FAIL stream_tail got we=%b ptr=%0d di=%h want 1 20 b4", rf_we, rf_ptr_w, rf_di);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    alu_valid = 1; alu_ptr = 5'd9;  alu_data = 8'h99;
    mem_valid = 1; mem_ptr = 5'd10; mem_data = 8'hAA; chk_ptr = 5'd9;
    @(posedge clk);
    #2;
    alu_valid = 0; mem_valid = 0;
    checks++;
    if (alu_ready !== 1'b0 || rf_we !== 1'b1) begin
      failures++;
      $display("FAIL both_full_pre_reset got ar=%b we=%b want 0 1", alu_ready, rf_we);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (rf_we !== 1'b0 || alu_ready !== 1'b1 || mem_ready !== 1'b1 || chk_busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got we=%b ar=%b mr=%b busy=%b want 0 1 1 0", rf_we, alu_ready, mem_ready, chk_busy);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_write_%0d got we=%b want 0", i, rf_we);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_same_ptr();
    test_zero_ptr();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, register data width; PTR_W, default 5, register pointer width.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_ptr  in  PTR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle when high with alu_valid.
- mem_valid  in  1  load writeback request.
- mem_ptr  in  PTR_W  load destination register.
- mem_data  in  DATA_W  load result.
- mem_ready  out  1  load request accepted this cycle when high with mem_valid.
- rf_we  out  1  register file write enable.
- rf_ptr_w  out  PTR_W  register file write pointer.
- rf_di  out  DATA_W  register file write data.
- chk_ptr  in  PTR_W  hazard query pointer (read port a or b).
- chk_busy  out  1  a pending write targets chk_ptr.
- chk_data  out  DATA_W  forwarded data of the youngest pending write to chk_ptr.

Function
REQ-003 SHALL hold one pending entry per requester (ALU, MEM), each with full, ptr, data and age state.
REQ-004 SHALL accept a request on a rising edge when valid and ready are both high, loading the entry and setting full.
REQ-005 SHALL drive x_ready = !full_x OR grant_x; ready SHALL NOT depend combinationally on any valid input.
REQ-006 SHALL grant the write port to at most one full entry per cycle; a granted entry clears at the edge unless refilled at the same edge.
REQ-007 Grant policy: only one entry full -> grant it; both full -> grant the older entry.
REQ-008 Age: an entry loaded while the other is full is younger; entries loaded at the same edge -> MEM older.
REQ-009 SHALL drive rf_we, rf_ptr_w and rf_di combinationally from the granted entry; write latency is one cycle from acceptance to register file commit.
REQ-010 A granted entry with ptr == 0 SHALL drain with rf_we = 0, because register 0 reads as zero.
REQ-011 No grant -> rf_we = 0, rf_ptr_w = 0, rf_di = 0.
REQ-012 chk_busy = 1 iff some full entry has ptr == chk_ptr and chk_ptr != 0.
REQ-013 chk_data SHALL come from the youngest matching entry, and SHALL be 0 when chk_busy = 0.
REQ-014 Same-pointer ordering: the two entries SHALL commit in acceptance order, so the last-accepted value remains in the register file.
REQ-015 A refill at the same edge as a drain SHALL sustain one write per cycle per requester; with both streaming, writes SHALL alternate by age.

Reset
REQ-016 reset SHALL asynchronously clear both full flags and age state.
REQ-017 While reset is high: rf_we = 0, chk_busy = 0, chk_data = 0, alu_ready = 1, mem_ready = 1.
REQ-018 Reset mid-operation SHALL discard pending entries without any register file write.

Structure
REQ-019 Shared package rf_pkg SHALL hold DATA_W, PTR_W, the REG_ZERO constant and the requester enum {REQ_ALU, REQ_MEM}.
REQ-020 The one-entry holding register SHALL be sub-module wb_hold, instantiated twice.

Verification
REQ-021 alu_valid with ptr 3, data 0x5A, idle -> next cycle rf_we = 1, rf_ptr_w = 3, rf_di = 0x5A; chk_ptr = 3 gives busy = 1 and data 0x5A for that cycle.
REQ-022 ALU and MEM valid at the same edge (ptrs 2 and 4) -> MEM writes ptr 4 first, ALU writes ptr 2 the next cycle; alu_ready = 0 for one cycle.
REQ-023 MEM ptr 5 = 0x11 is pending, ALU ptr 5 = 0x22 is accepted one cycle later -> chk_data = 0x22; commits are 0x11 then 0x22.
REQ-024 ALU ptr 0 with data 0xFF -> entry drains in one cycle, rf_we stays 0, chk_busy = 0 for chk_ptr = 0.
REQ-025 Both entries full, reset asserted asynchronously -> rf_we = 0 and both ready = 1 immediately; no write after reset releases.
REQ-026 ALU and MEM each valid every cycle for 8 cycles -> 8 commits, one per cycle, alternating by age, none lost.
